dcache_writeback_buffer: RTL and testbench
==========================================

DCACHE_WRITEBACK_BUFFER -- requirements
Module: dcache_writeback_buffer

Interface
REQ-001 SHALL have parameter OFFSET_WIDTH, default 5, byte-offset bits per cache line (line = 2^OFFSET_WIDTH bytes).
REQ-002 SHALL have parameter WORDS, default 2^(OFFSET_WIDTH-2) = 8, 32-bit words per line; WORDS SHALL NOT be overridden independently of OFFSET_WIDTH.
REQ-003 SHALL have ports:
clk  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
evict_valid  in  1  cache offers a dirty victim line
evict_ready  out  1  buffer can accept a victim
evict_addr  in  32  victim line base address; low OFFSET_WIDTH bits ignored
evict_data  in  32*WORDS  victim line; word i at bits [32i+31:32i]
wr_req  out  1  memory write beat valid
wr_addr  out  32  byte address of current beat
wr_data  out  32  current beat data
wr_last  out  1  current beat is final beat of line
wr_ready  in  1  memory accepts beat this cycle
wr_resp  in  1  memory write-complete response, single-cycle pulse
rd_check_addr  in  32  address of a pending cache refill
rd_conflict  out  1  rd_check_addr falls in the line held in the buffer
busy  out  1  buffer occupied

Function
REQ-004 SHALL implement FSM states IDLE, SEND, WAIT_RESP.
REQ-005 IDLE: evict_ready=1; on evict_valid=1 SHALL latch evict_addr with low OFFSET_WIDTH bits cleared, latch all of evict_data, clear beat counter, and go to SEND the next cycle.
REQ-006 evict_ready SHALL be 1 only in IDLE; a victim SHALL be captured only on evict_valid && evict_ready.
REQ-007 SEND: wr_req=1, wr_data = latched word[beat], wr_addr = latched base + 4*beat, wr_last = (beat == WORDS-1).
REQ-008 In SEND, wr_ready=1 SHALL advance beat by 1; wr_ready=0 SHALL hold beat, wr_addr and wr_data stable.
REQ-009 wr_ready=1 with wr_last=1 SHALL move to WAIT_RESP the next cycle; the beat counter SHALL NOT wrap past WORDS-1.
REQ-010 WAIT_RESP: wr_req=0; wr_resp=1 SHALL return the FSM to IDLE the next cycle.
REQ-011 wr_resp asserted in IDLE or SEND SHALL be ignored.
REQ-012 First beat SHALL be presented exactly 1 cycle after capture; a line SHALL take at least WORDS+2 cycles from capture to evict_ready=1.
REQ-013 busy SHALL be 1 in SEND and WAIT_RESP and 0 in IDLE.
REQ-014 rd_conflict SHALL be combinational: busy && rd_check_addr[31:OFFSET_WIDTH] == latched base[31:OFFSET_WIDTH]; rd_conflict SHALL be 0 in IDLE.
REQ-015 rd_conflict SHALL remain 1 through WAIT_RESP until the FSM returns to IDLE, so a refill never reads memory before the write completes.
REQ-016 wr_addr SHALL wrap modulo 2^32; no other address arithmetic SHALL carry into the tag.

Reset
REQ-017 reset=1 SHALL put the FSM in IDLE, beat counter 0, latched address and data 0, on the next rising edge, regardless of state.
REQ-018 After reset: evict_ready=1, wr_req=0, wr_last=0, wr_addr=0, wr_data=0, busy=0, rd_conflict=0.
REQ-019 reset mid-SEND or mid-WAIT_RESP SHALL abandon the line without issuing further beats; a later wr_resp SHALL be ignored.

Structure
REQ-020 FSM state enum, OFFSET_WIDTH default (CACHE_B) and word-size constants SHALL reside in the shared dcache package with the other dCache definitions.
REQ-021 Sub-module dcache_wb_beat_counter (beat count, wr_last generation) is natural; all else SHALL be flat in one module.

Verification
REQ-022 Reset, then evict_valid=1, evict_addr=0x1000_0014, data words 0..7 = 0xA0..0xA7, wr_ready=1 always -> beats at 0x1000_0000..0x1000_001C with data 0xA0..0xA7, wr_last only on beat 7, then WAIT_RESP.
REQ-023 Same line, wr_ready toggling 1,0,1,0 -> each beat held while wr_ready=0; eight beats total, no duplicates or skips.
REQ-024 In WAIT_RESP, rd_check_addr=0x1000_0008 -> rd_conflict=1; rd_check_addr=0x1000_0020 -> 0; wr_resp pulse -> IDLE next cycle, rd_conflict=0, evict_ready=1.
REQ-025 evict_valid=1 held during SEND with a second line -> not captured until IDLE; second line then sent intact.
REQ-026 reset=1 at beat 3 -> next cycle wr_req=0, busy=0, evict_ready=1; subsequent wr_resp pulse causes no state change.
REQ-027 evict_addr=0xFFFF_FFE0 -> beat addresses 0xFFFF_FFE0..0xFFFF_FFFC, no carry errors.

Source files
------------

// File: rtl/dcache_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : dcache_pkg                                                   |
// | Shared data-cache definitions: line geometry, word-size constants and  |
// | the write-back buffer FSM state encoding.                              |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package dcache_pkg;

  // Byte-offset bits per cache line (32-byte lines by default).
  localparam int CACHE_B    = 5;
  // Memory word geometry.
  localparam int WORD_BITS  = 32;
  localparam int WORD_OFF_B = 2;

  typedef enum logic [1:0] {
    WB_IDLE      = 2'd0,
    WB_SEND      = 2'd1,
    WB_WAIT_RESP = 2'd2
  } wb_state_e;

  // Number of 32-bit words in a line of 2**offset_width bytes.
  function automatic int words_per_line(input int offset_width);
    return 1 << (offset_width - WORD_OFF_B);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_wb_beat_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : dcache_wb_beat_counter                                       |
// | Beat index for a line write-back. Cleared on capture, advanced on each |
// | accepted beat, saturates at the final beat; flags the final beat.      |
// | Ports   : clk, reset   - clock / synchronous active-high reset         |
// |           clear        - restart at beat 0                             |
// |           advance      - current beat accepted by memory               |
// |           active       - a line is being streamed (qualifies last)     |
// |           beat         - current beat index                            |
// |           last         - current beat is the final beat of the line    |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module dcache_wb_beat_counter #(
  parameter int BEAT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic              active,
  output logic [BEAT_W-1:0] beat,
  output logic              last
);

  // Line word count is a power of two, so the final beat is all ones.
  localparam logic [BEAT_W-1:0] LAST_BEAT = '1;

  logic [BEAT_W-1:0] r_beat;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_beat <= '0;
    end else if (advance && (r_beat != LAST_BEAT)) begin
      // Saturate: the final accepted beat leaves the index at LAST_BEAT.
      r_beat <= r_beat + 1'b1;
    end
  end

  assign beat = r_beat;
  assign last = active && (r_beat == LAST_BEAT);

endmodule
`default_nettype wire

// File: rtl/dcache_writeback_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : dcache_writeback_buffer                                      |
// | Holds one dirty victim line and streams it to memory one 32-bit beat   |
// | at a time, then waits for the write-complete response. Flags refills   |
// | that target the held line until the write has completed.              |
// | Ports   : clk, reset              - clock / sync active-high reset     |
// |           evict_valid/ready/addr/data - victim line handshake          |
// |           wr_req/addr/data/last, wr_ready - memory write beat channel  |
// |           wr_resp                 - memory write-complete pulse        |
// |           rd_check_addr, rd_conflict - refill hazard check             |
// |           busy                    - buffer occupied                    |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module dcache_writeback_buffer
  import dcache_pkg::*;
#(
  parameter int OFFSET_WIDTH = CACHE_B,
  parameter int WORDS        = words_per_line(OFFSET_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    evict_valid,
  output logic                    evict_ready,
  input  logic [31:0]             evict_addr,
  input  logic [WORD_BITS*WORDS-1:0] evict_data,
  output logic                    wr_req,
  output logic [31:0]             wr_addr,
  output logic [31:0]             wr_data,
  output logic                    wr_last,
  input  logic                    wr_ready,
  input  logic                    wr_resp,
  input  logic [31:0]             rd_check_addr,
  output logic                    rd_conflict,
  output logic                    busy
);

  localparam int BEAT_W = OFFSET_WIDTH - WORD_OFF_B;

  // WORDS is derived from the line size; an independent override would
  // break the beat-index width below.
  if (WORDS != (1 << BEAT_W)) begin : g_words_check
    $error("WORDS must equal 2**(OFFSET_WIDTH-2)");
  end

  wb_state_e          r_state;
  logic [31:0]        r_base;
  logic [31:0]        r_line [WORDS];
  logic [BEAT_W-1:0]  w_beat;
  logic               w_last;
  logic               w_capture;
  logic               w_unused_offsets;

  assign w_capture = (r_state == WB_IDLE) && evict_valid;

  dcache_wb_beat_counter #(
    .BEAT_W (BEAT_W)
  ) u_beat_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_capture),
    .advance ((r_state == WB_SEND) && wr_ready),
    .active  (r_state == WB_SEND),
    .beat    (w_beat),
    .last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WB_IDLE;
      r_base  <= '0;
      for (int i = 0; i < WORDS; i++) begin
        r_line[i] <= '0;
      end
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (evict_valid) begin
            r_base <= {evict_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
            for (int i = 0; i < WORDS; i++) begin
              r_line[i] <= evict_data[WORD_BITS*i +: WORD_BITS];
            end
            r_state <= WB_SEND;
          end
        end
        WB_SEND: begin
          if (wr_ready && w_last) begin
            r_state <= WB_WAIT_RESP;
          end
        end
        WB_WAIT_RESP: begin
          if (wr_resp) begin
            r_state <= WB_IDLE;
          end
        end
        default: r_state <= WB_IDLE;
      endcase
    end
  end

  assign evict_ready = (r_state == WB_IDLE);
  assign wr_req      = (r_state == WB_SEND);
  assign busy        = (r_state != WB_IDLE);
  assign wr_last     = w_last;
  assign wr_data     = r_line[w_beat];
  // Base has a zero offset field, so the beat address is a pure splice:
  // nothing can carry into the tag.
  assign wr_addr     = {r_base[31:OFFSET_WIDTH], w_beat, {WORD_OFF_B{1'b0}}};

  // Held until the FSM leaves WAIT_RESP so a refill cannot overtake the write.
  assign rd_conflict = busy &&
                       (rd_check_addr[31:OFFSET_WIDTH] == r_base[31:OFFSET_WIDTH]);

  assign w_unused_offsets = ^{evict_addr[OFFSET_WIDTH-1:0],
                              rd_check_addr[OFFSET_WIDTH-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_dcache_writeback_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_dcache_writeback_buffer                                   |
// | Self-checking bench: table-driven directed sequences plus randomized   |
// | traffic compared against a line-level reference model.                 |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_dcache_writeback_buffer;

  localparam int OW = 5;
  localparam int NW = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } beat_vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        conflict;
  } conf_vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            evict_valid;
  logic            evict_ready;
  logic [31:0]     evict_addr;
  logic [32*NW-1:0] evict_data;
  logic            wr_req;
  logic [31:0]     wr_addr;
  logic [31:0]     wr_data;
  logic            wr_last;
  logic            wr_ready;
  logic            wr_resp;
  logic [31:0]     rd_check_addr;
  logic            rd_conflict;
  logic            busy;

  int total = 0;
  int bad   = 0;

  beat_vec_t beat_tab [NW];
  conf_vec_t conf_tab [5];

  // Reference model: a held line and how many of its beats were accepted.
  bit          m_held;
  int          m_done;
  logic [31:0] m_base;
  logic [31:0] m_words [NW];

  always #5 clk = ~clk;

  dcache_writeback_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .evict_valid   (evict_valid),
    .evict_ready   (evict_ready),
    .evict_addr    (evict_addr),
    .evict_data    (evict_data),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .wr_ready      (wr_ready),
    .wr_resp       (wr_resp),
    .rd_check_addr (rd_check_addr),
    .rd_conflict   (rd_conflict),
    .busy          (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resp_pulse();
    wr_resp = 1'b1;
    step();
    wr_resp = 1'b0;
  endtask

  // Streams a captured line with wr_ready held high, checking every beat.
  task automatic expect_line(input string tag, input logic [31:0] base,
                             input logic [32*NW-1:0] line);
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("%s_req%0d", tag, i), 32'(wr_req), 32'd1);
      chk($sformatf("%s_addr%0d", tag, i), wr_addr, base + 32'(4 * i));
      chk($sformatf("%s_data%0d", tag, i), wr_data, line[32*i +: 32]);
      chk($sformatf("%s_last%0d", tag, i), 32'(wr_last), 32'(i == NW - 1));
      step();
    end
    chk($sformatf("%s_wait_req", tag), 32'(wr_req), 32'd0);
    chk($sformatf("%s_wait_busy", tag), 32'(busy), 32'd1);
    chk($sformatf("%s_wait_ready", tag), 32'(evict_ready), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32*NW-1:0] line_a;
    logic [32*NW-1:0] line_b;
    logic [32*NW-1:0] line_c;
    int k;

    for (int i = 0; i < NW; i++) begin
      line_a[32*i +: 32] = 32'hA0 + 32'(i);
      line_b[32*i +: 32] = 32'hB0 + 32'(i);
      line_c[32*i +: 32] = $urandom;
      beat_tab[i].addr = 32'h1000_0000 + 32'(4 * i);
      beat_tab[i].data = 32'hA0 + 32'(i);
      beat_tab[i].last = (i == NW - 1);
    end
    conf_tab[0] = '{32'h1000_0008, 1'b1};
    conf_tab[1] = '{32'h1000_0020, 1'b0};
    conf_tab[2] = '{32'h1000_001C, 1'b1};
    conf_tab[3] = '{32'h0FFF_FFFC, 1'b0};
    conf_tab[4] = '{32'h1000_0000, 1'b1};

    reset = 1'b1; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
    wr_ready = 1'b0; wr_resp = 1'b0; rd_check_addr = '0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_evict_ready", 32'(evict_ready), 32'd1);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_wr_last", 32'(wr_last), 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_conflict", 32'(rd_conflict), 32'd0);

    // Basic line, memory always ready; unaligned address must be masked.
    evict_valid = 1'b1; evict_addr = 32'h1000_0014; evict_data = line_a; wr_ready = 1'b1;
    step();
    evict_valid = 1'b0;
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("tab_req%0d", i), 32'(wr_req), 32'd1);
      chk($sformatf("tab_addr%0d", i), wr_addr, beat_tab[i].addr);
      chk($sformatf("tab_data%0d", i), wr_data, beat_tab[i].data);
      chk($sformatf("tab_last%0d", i), 32'(wr_last), 32'(beat_tab[i].last));
      step();
    end
    chk("wait_req", 32'(wr_req), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);

    // Refill hazard while waiting for the write response.
    for (int i = 0; i < 5; i++) begin
      rd_check_addr = conf_tab[i].rd;
      #1;
      chk($sformatf("conf%0d", i), 32'(rd_conflict), 32'(conf_tab[i].conflict));
    end
    rd_check_addr = 32'h1000_0008;
    resp_pulse();
    chk("resp_ready", 32'(evict_ready), 32'd1);
    chk("resp_busy", 32'(busy), 32'd0);
    chk("resp_conflict", 32'(rd_conflict), 32'd0);

    // Back-pressure with a second victim waiting behind the first.
    evict_valid = 1'b1; evict_addr = 32'h1000_0014; evict_data = line_a; wr_ready = 1'b0;
    step();
    evict_addr = 32'h2000_0040; evict_data = line_b;
    k = 0;
    for (int c = 0; c < 40 && k < NW; c++) begin
      wr_ready = (c % 2 == 0);
      #1;
      chk("bp_evict_ready", 32'(evict_ready), 32'd0);
      chk("bp_req", 32'(wr_req), 32'd1);
      chk("bp_addr", wr_addr, 32'h1000_0000 + 32'(4 * k));
      chk("bp_data", wr_data, 32'hA0 + 32'(k));
      chk("bp_last", 32'(wr_last), 32'(k == NW - 1));
      if (wr_ready) k++;
      step();
    end
    chk("bp_beats_total", 32'(k), 32'(NW));
    chk("bp_wait_req", 32'(wr_req), 32'd0);
    wr_ready = 1'b1;
    step();
    chk("bp_wait_ready", 32'(evict_ready), 32'd0);
    resp_pulse();
    chk("second_idle_ready", 32'(evict_ready), 32'd1);
    step();
    evict_valid = 1'b0;
    expect_line("line2", 32'h2000_0040, line_b);
    resp_pulse();

    // Top-of-memory line: beat addresses must not carry.
    evict_valid = 1'b1; evict_addr = 32'hFFFF_FFF7; evict_data = line_c;
    step();
    evict_valid = 1'b0;
    expect_line("top", 32'hFFFF_FFE0, line_c);
    resp_pulse();

    // Reset in the middle of a line, then a stale response.
    evict_valid = 1'b1; evict_addr = 32'h3000_0000; evict_data = line_a;
    step();
    evict_valid = 1'b0;
    step(); step(); step();
    chk("mid_addr_beat3", wr_addr, 32'h3000_000C);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_req", 32'(wr_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(evict_ready), 32'd1);
    chk("mid_rst_addr", wr_addr, 32'd0);
    resp_pulse();
    chk("stale_resp_req", 32'(wr_req), 32'd0);
    chk("stale_resp_busy", 32'(busy), 32'd0);
    chk("stale_resp_ready", 32'(evict_ready), 32'd1);

    // Randomized traffic against the reference model (starts from reset).
    reset = 1'b1;
    step();
    m_held = 1'b0; m_done = 0; m_base = '0;
    for (int i = 0; i < NW; i++) m_words[i] = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        e_req;
      logic [31:0] e_addr;
      reset       = ($urandom_range(0, 99) == 0);
      evict_valid = ($urandom_range(0, 2) == 0);
      evict_addr  = $urandom;
      for (int i = 0; i < NW; i++) evict_data[32*i +: 32] = $urandom;
      wr_ready    = $urandom_range(0, 1) == 1;
      wr_resp     = ($urandom_range(0, 5) == 0);
      rd_check_addr = ($urandom_range(0, 1) == 1) ? (m_base | 32'($urandom_range(0, 31)))
                                                  : $urandom;
      #1;
      e_req = m_held && (m_done < NW);
      chk("rnd_evict_ready", 32'(evict_ready), 32'(!m_held));
      chk("rnd_req", 32'(wr_req), 32'(e_req));
      chk("rnd_busy", 32'(busy), 32'(m_held));
      chk("rnd_conflict", 32'(rd_conflict),
          32'(m_held && ((rd_check_addr >> OW) == (m_base >> OW))));
      chk("rnd_last", 32'(wr_last), 32'(e_req && (m_done == NW - 1)));
      if (e_req) begin
        e_addr = m_base + 32'(4 * m_done);
        chk("rnd_addr", wr_addr, e_addr);
        chk("rnd_data", wr_data, m_words[m_done]);
      end
      @(posedge clk);
      if (reset) begin
        m_held = 1'b0; m_done = 0; m_base = '0;
        for (int i = 0; i < NW; i++) m_words[i] = '0;
      end else if (!m_held) begin
        if (evict_valid) begin
          m_held = 1'b1;
          m_done = 0;
          m_base = evict_addr & ~32'(2 ** OW - 1);
          for (int i = 0; i < NW; i++) m_words[i] = evict_data[32*i +: 32];
        end
      end else if (m_done < NW) begin
        if (wr_ready) m_done++;
      end else if (wr_resp) begin
        m_held = 1'b0;
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
